// File: rtl/vram_pkg.sv
// Shared constants for the VRAM arbiter: slot-owner tags, default address width
// and the fixed RAM read latency seen by the requesters.
package vram_pkg;

  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_VID  = 2'd1,
    SLOT_CPU  = 2'd2
  } slot_e;

  localparam int VRAM_AW   = 12;
  localparam int VRAM_RLAT = 2;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer for CPU writes into VRAM.
// Only instantiated when VRAM_ARB_WPOST_EN is defined.
module vram_wbuf import vram_pkg::*; #(
  parameter int AW = VRAM_AW
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  input  logic          drain_i,
  output logic          full_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    data_o
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (drain_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scanout has priority, CPU gets an override after
// CPU_MAXWAIT stalled cycles. VRAM_ARB_WPOST_EN enables posted CPU writes.
module vram_arbiter import vram_pkg::*; #(
  parameter int AW          = VRAM_AW,
  parameter int CPU_MAXWAIT = 15
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          VREQ,
  input  logic [AW-1:0] VADDR,
  output logic [7:0]    VDATA,
  output logic          VVALID,
  output logic          VMISS,
  input  logic          CREQ,
  input  logic          CWE,
  input  logic [AW-1:0] CADDR,
  input  logic [7:0]    CDIN,
  output logic [7:0]    CDOUT,
  output logic          CACK,
  output logic [AW-1:0] RADDR,
  output logic          RWE,
  output logic [7:0]    RWDATA,
  input  logic [7:0]    RRDATA
);

  localparam int CW = (CPU_MAXWAIT > 0) ? $clog2(CPU_MAXWAIT + 1) : 1;
  localparam logic [CW-1:0] MAXW = CW'(CPU_MAXWAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, vmiss_q, vmiss_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          rwe_q, rwe_d;
  logic [7:0]    rwdata_q, rwdata_d, vdata_q, vdata_d, cdout_q, cdout_d;
  logic          vvalid_q, vvalid_d, cack_q, cack_d;
  slot_e         tag_q [VRAM_RLAT];
  slot_e         tag_d [VRAM_RLAT];

  logic          cpu_ok, cpu_cand, cand_we, ack_now, ovr, rd_done;
  logic [AW-1:0] cand_addr;
  logic [7:0]    cand_data;
  slot_e         sel;

`ifdef VRAM_ARB_WPOST_EN
  logic          wb_full, wb_load, wb_drain;
  logic [AW-1:0] wb_addr;
  logic [7:0]    wb_data;

  // A full buffer blocks every new CPU request until its drain slot has issued.
  assign cpu_ok    = CREQ && !busy_q && !cack_q && !wb_full;
  assign wb_load   = cpu_ok && CWE;
  assign cpu_cand  = wb_full || (cpu_ok && !CWE);
  assign cand_we   = wb_full;
  assign cand_addr = wb_full ? wb_addr : CADDR;
  assign cand_data = wb_data;
  assign wb_drain  = (sel == SLOT_CPU) && wb_full;
  assign ack_now   = wb_load;

  vram_wbuf #(.AW(AW)) u_wbuf (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .load_i  (wb_load),
    .addr_i  (CADDR),
    .data_i  (CDIN),
    .drain_i (wb_drain),
    .full_o  (wb_full),
    .addr_o  (wb_addr),
    .data_o  (wb_data)
  );
`else
  // A CREQ still high in its own CACK cycle is the finished op, not a new one.
  assign cpu_ok    = CREQ && !busy_q && !cack_q;
  assign cpu_cand  = cpu_ok;
  assign cand_we   = CWE;
  assign cand_addr = CADDR;
  assign cand_data = CDIN;
  assign ack_now   = (sel == SLOT_CPU) && cand_we;
`endif

  always_comb begin
    ovr = cpu_cand && (CPU_MAXWAIT != 0) && (cnt_q == MAXW);
    if (ovr)           sel = SLOT_CPU;
    else if (VREQ)     sel = SLOT_VID;
    else if (cpu_cand) sel = SLOT_CPU;
    else               sel = SLOT_NONE;
  end

  always_comb begin
    raddr_d  = raddr_q;
    rwdata_d = rwdata_q;
    rwe_d    = 1'b0;
    case (sel)
      SLOT_VID: raddr_d = VADDR;
      SLOT_CPU: begin
        raddr_d = cand_addr;
        rwe_d   = cand_we;
        if (cand_we) rwdata_d = cand_data;
      end
      default: ;
    endcase

    // Writes return no data, so they enter the tag pipeline as empty slots.
    tag_d[0] = (sel == SLOT_CPU && cand_we) ? SLOT_NONE : sel;
    for (int i = 1; i < VRAM_RLAT; i++) tag_d[i] = tag_q[i-1];

    rd_done  = (tag_q[VRAM_RLAT-1] == SLOT_CPU);
    vvalid_d = (tag_q[VRAM_RLAT-1] == SLOT_VID);
    vdata_d  = vvalid_d ? RRDATA : vdata_q;
    cdout_d  = rd_done ? RRDATA : cdout_q;
    cack_d   = rd_done || ack_now;
    busy_d   = (busy_q && !rd_done) || (sel == SLOT_CPU && !cand_we);
    vmiss_d  = vmiss_q || (ovr && VREQ);

    if (sel == SLOT_CPU || !cpu_cand) cnt_d = '0;
    else if (cnt_q != MAXW)           cnt_d = cnt_q + 1'b1;
    else                              cnt_d = cnt_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      vmiss_q  <= 1'b0;
      raddr_q  <= '0;
      rwe_q    <= 1'b0;
      rwdata_q <= '0;
      vdata_q  <= '0;
      vvalid_q <= 1'b0;
      cdout_q  <= '0;
      cack_q   <= 1'b0;
      for (int i = 0; i < VRAM_RLAT; i++) tag_q[i] <= SLOT_NONE;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      vmiss_q  <= vmiss_d;
      raddr_q  <= raddr_d;
      rwe_q    <= rwe_d;
      rwdata_q <= rwdata_d;
      vdata_q  <= vdata_d;
      vvalid_q <= vvalid_d;
      cdout_q  <= cdout_d;
      cack_q   <= cack_d;
      for (int i = 0; i < VRAM_RLAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign VDATA  = vdata_q;
  assign VVALID = vvalid_q;
  assign VMISS  = vmiss_q;
  assign CDOUT  = cdout_q;
  assign CACK   = cack_q;
  assign RADDR  = raddr_q;
  assign RWE    = rwe_q;
  assign RWDATA = rwdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: DUT A uses CPU_MAXWAIT=15, DUT B uses 0.
// Each DUT has its own behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          vreq, creq, cwe, vvalid, vmiss, cack, rwe;
  logic [AW-1:0] vaddr, caddr, raddr;
  logic [7:0]    cdin, vdata, cdout, rwdata, rrdata;

  logic          b_vreq, b_creq, b_cwe, b_vvalid, b_vmiss, b_cack, b_rwe;
  logic [AW-1:0] b_vaddr, b_caddr, b_raddr;
  logic [7:0]    b_cdin, b_vdata, b_cdout, b_rwdata, b_rrdata;

  logic [7:0] mem_a [1<<AW];
  logic [7:0] mem_b [1<<AW];
  logic [7:0] exp_mem [1<<AW];
  logic [7:0] vq [$];
  logic [7:0] cq [$];
  int n_cmp = 0;
  int n_bad = 0;

  vram_arbiter #(.AW(AW), .CPU_MAXWAIT(15)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .VREQ(vreq), .VADDR(vaddr), .VDATA(vdata),
    .VVALID(vvalid), .VMISS(vmiss), .CREQ(creq), .CWE(cwe), .CADDR(caddr),
    .CDIN(cdin), .CDOUT(cdout), .CACK(cack), .RADDR(raddr), .RWE(rwe),
    .RWDATA(rwdata), .RRDATA(rrdata)
  );

  vram_arbiter #(.AW(AW), .CPU_MAXWAIT(0)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .VREQ(b_vreq), .VADDR(b_vaddr), .VDATA(b_vdata),
    .VVALID(b_vvalid), .VMISS(b_vmiss), .CREQ(b_creq), .CWE(b_cwe), .CADDR(b_caddr),
    .CDIN(b_cdin), .CDOUT(b_cdout), .CACK(b_cack), .RADDR(b_raddr), .RWE(b_rwe),
    .RWDATA(b_rwdata), .RRDATA(b_rrdata)
  );

  always @(posedge clk) begin
    if (rwe) mem_a[raddr] <= rwdata;
    rrdata <= mem_a[raddr];
  end

  always @(posedge clk) begin
    if (b_rwe) mem_b[b_raddr] <= b_rwdata;
    b_rrdata <= mem_b[b_raddr];
  end

  task automatic test_reset();
    logic saw;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({vdata, vvalid, vmiss, cdout, cack, raddr, rwe, rwdata} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {vdata, vvalid, vmiss, cdout, cack, raddr, rwe, rwdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    creq = 1'b1; cwe = 1'b0; caddr = 12'h033;
    @(negedge clk);
    n_cmp++;
    if (raddr !== 12'h033) begin
      n_bad++; $display("FAIL reset_read_issue: raddr %h expected 033", raddr);
    end
    rst_n = 1'b0; creq = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({vdata, vvalid, vmiss, cdout, cack, raddr, rwe, rwdata} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_midread_outputs: got %h expected 0", {vdata, vvalid, vmiss, cdout, cack, raddr, rwe, rwdata});
    end
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cack || vvalid) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_bad++; $display("FAIL reset_discard: ack/valid seen %b expected 0", saw);
    end
    n_cmp++;
    if (vmiss !== 1'b0) begin
      n_bad++; $display("FAIL reset_vmiss: got %b expected 0", vmiss);
    end
  endtask

  task automatic test_vid_burst();
    int first, last, nv;
    logic [7:0] e;
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (vvalid) begin
        if (first < 0) first = i;
        last = i; nv++;
        n_cmp++;
        if (vq.size() == 0) begin
          n_bad++; $display("FAIL burst_extra: vdata %h with nothing expected", vdata);
        end else begin
          e = vq.pop_front();
          if (vdata !== e) begin n_bad++; $display("FAIL burst_data: got %h expected %h", vdata, e); end
        end
      end
      if (i < 8) begin
        vreq = 1'b1; vaddr = AW'(i); vq.push_back(exp_mem[AW'(i)]);
      end else vreq = 1'b0;
    end
    n_cmp++;
    if (first !== 3) begin n_bad++; $display("FAIL burst_latency: first valid idx %0d expected 3", first); end
    n_cmp++;
    if (nv !== 8 || last - first + 1 !== 8) begin
      n_bad++; $display("FAIL burst_count: %0d valids over %0d cycles expected 8/8", nv, last - first + 1);
    end
    n_cmp++;
    if (vq.size() !== 0) begin n_bad++; $display("FAIL burst_missing: %0d left expected 0", vq.size()); end
    vq.delete();
  endtask

  task automatic test_collision();
    int ack_i, rwe_i, exp_ack;
    logic [7:0] e;
`ifdef VRAM_ARB_WPOST_EN
    exp_ack = 1;
`else
    exp_ack = 2;
`endif
    ack_i = -1; rwe_i = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vvalid) begin
        n_cmp++; e = vq.pop_front();
        if (vdata !== e) begin n_bad++; $display("FAIL coll_vdata: got %h expected %h", vdata, e); end
      end
      if (i == 1) begin
        n_cmp++;
        if (raddr !== 12'h010 || rwe !== 1'b0) begin
          n_bad++; $display("FAIL coll_video_first: raddr %h rwe %b expected 010/0", raddr, rwe);
        end
      end
      if (cack && ack_i < 0) begin ack_i = i; creq = 1'b0; end
      if (rwe && rwe_i < 0) begin
        rwe_i = i; n_cmp++;
        if (raddr !== 12'h020 || rwdata !== 8'h5A) begin
          n_bad++; $display("FAIL coll_write: raddr %h data %h expected 020/5a", raddr, rwdata);
        end
      end
      if (i == 0) begin
        vreq = 1'b1; vaddr = 12'h010; vq.push_back(exp_mem[12'h010]);
        creq = 1'b1; cwe = 1'b1; caddr = 12'h020; cdin = 8'h5A;
      end else vreq = 1'b0;
    end
    exp_mem[12'h020] = 8'h5A;
    n_cmp++;
    if (ack_i !== exp_ack || rwe_i !== 2) begin
      n_bad++; $display("FAIL coll_timing: cack idx %0d rwe idx %0d expected %0d/2", ack_i, rwe_i, exp_ack);
    end
    ack_i = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cack && ack_i < 0) begin
        ack_i = i; creq = 1'b0; n_cmp++; e = cq.pop_front();
        if (cdout !== e) begin n_bad++; $display("FAIL readback_data: got %h expected %h", cdout, e); end
      end
      if (i == 0) begin
        creq = 1'b1; cwe = 1'b0; caddr = 12'h020; cq.push_back(exp_mem[12'h020]);
      end
    end
    n_cmp++;
    if (ack_i !== 3) begin n_bad++; $display("FAIL readback_latency: cack idx %0d expected 3", ack_i); end
    vq.delete(); cq.delete(); creq = 1'b0;
  endtask

  task automatic test_override();
    int ack_i, miss_i, ovr_i;
    logic [7:0] e;
    ack_i = -1; miss_i = -1; ovr_i = -1;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (vvalid) begin
        n_cmp++;
        if (vq.size() == 0) begin
          n_bad++; $display("FAIL ovr_extra_video: vdata %h with nothing expected", vdata);
        end else begin
          e = vq.pop_front();
          if (vdata !== e) begin n_bad++; $display("FAIL ovr_vdata: got %h expected %h", vdata, e); end
        end
      end
      if (vmiss && miss_i < 0) miss_i = i;
      if (!rwe && raddr == 12'h030 && ovr_i < 0) ovr_i = i;
      if (cack && ack_i < 0) begin
        ack_i = i; creq = 1'b0; n_cmp++; e = cq.pop_front();
        if (cdout !== e) begin n_bad++; $display("FAIL ovr_cdout: got %h expected %h", cdout, e); end
      end
      if (i == 0) begin
        creq = 1'b1; cwe = 1'b0; caddr = 12'h030; cq.push_back(exp_mem[12'h030]);
      end
      if (i < 22) begin
        vreq = 1'b1; vaddr = AW'(12'h100 + i);
        if (i != 15) vq.push_back(exp_mem[vaddr]);
      end else vreq = 1'b0;
    end
    n_cmp++;
    if (ovr_i !== 16) begin n_bad++; $display("FAIL ovr_grant: grant idx %0d expected 16", ovr_i); end
    n_cmp++;
    if (miss_i !== 16) begin n_bad++; $display("FAIL ovr_vmiss_set: idx %0d expected 16", miss_i); end
    n_cmp++;
    if (ack_i !== 18) begin n_bad++; $display("FAIL ovr_cack: idx %0d expected 18", ack_i); end
    n_cmp++;
    if (vq.size() !== 0) begin n_bad++; $display("FAIL ovr_missing_video: %0d left expected 0", vq.size()); end
    n_cmp++;
    if (vmiss !== 1'b1) begin n_bad++; $display("FAIL ovr_vmiss_sticky: got %b expected 1", vmiss); end
    vq.delete(); cq.delete();
  endtask

  task automatic test_no_override();
    int ack_i;
    logic saw_miss;
    logic [7:0] e;
    ack_i = -1; saw_miss = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b_vmiss) saw_miss = 1'b1;
      if (b_cack && ack_i < 0) begin
        ack_i = i; b_creq = 1'b0; n_cmp++; e = cq.pop_front();
        if (b_cdout !== e) begin n_bad++; $display("FAIL nowait_cdout: got %h expected %h", b_cdout, e); end
      end
      if (i == 0) begin
        b_creq = 1'b1; b_cwe = 1'b0; b_caddr = 12'h040; cq.push_back(exp_mem[12'h040]);
      end
      b_vreq = (i < 20); b_vaddr = AW'(12'h200 + i);
    end
    n_cmp++;
    if (ack_i !== 23) begin n_bad++; $display("FAIL nowait_cack: idx %0d expected 23", ack_i); end
    n_cmp++;
    if (saw_miss !== 1'b0) begin n_bad++; $display("FAIL nowait_vmiss: got %b expected 0", saw_miss); end
    cq.delete();
  endtask

`ifdef VRAM_ARB_WPOST_EN
  task automatic test_posted_write();
    int ack1, ack2, d1, d2;
    logic [7:0] e;
    ack1 = -1; ack2 = -1; d1 = -1; d2 = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (vvalid) begin
        n_cmp++; e = vq.pop_front();
        if (vdata !== e) begin n_bad++; $display("FAIL wpost_vdata: got %h expected %h", vdata, e); end
      end
      if (cack) begin
        if (ack1 < 0) begin ack1 = i; caddr = 12'h051; cdin = 8'h3C; end
        else if (ack2 < 0) begin ack2 = i; creq = 1'b0; end
      end
      if (rwe) begin
        n_cmp++;
        if (d1 < 0) begin
          d1 = i;
          if (raddr !== 12'h050 || rwdata !== 8'hA7) begin
            n_bad++; $display("FAIL wpost_drain1: %h/%h expected 050/a7", raddr, rwdata);
          end
        end else begin
          if (d2 < 0) d2 = i;
          if (raddr !== 12'h051 || rwdata !== 8'h3C) begin
            n_bad++; $display("FAIL wpost_drain2: %h/%h expected 051/3c", raddr, rwdata);
          end
        end
      end
      if (i == 0) begin creq = 1'b1; cwe = 1'b1; caddr = 12'h050; cdin = 8'hA7; end
      if (i < 20) begin
        vreq = 1'b1; vaddr = AW'(12'h180 + i);
        if (i != 16) vq.push_back(exp_mem[vaddr]);
      end else vreq = 1'b0;
    end
    n_cmp++;
    if (ack1 !== 1 || ack2 !== 18) begin
      n_bad++; $display("FAIL wpost_cack: idx %0d/%0d expected 1/18", ack1, ack2);
    end
    n_cmp++;
    if (d1 !== 17 || d2 !== 21) begin
      n_bad++; $display("FAIL wpost_drain_timing: idx %0d/%0d expected 17/21", d1, d2);
    end
    vq.delete(); creq = 1'b0;
  endtask
`endif

  initial begin
    vreq = 1'b0; creq = 1'b0; cwe = 1'b0; vaddr = '0; caddr = '0; cdin = '0;
    b_vreq = 1'b0; b_creq = 1'b0; b_cwe = 1'b0; b_vaddr = '0; b_caddr = '0; b_cdin = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = 8'(i); mem_b[i] = 8'(i); exp_mem[i] = 8'(i);
    end
    test_reset();
    test_vid_burst();
    test_collision();
    test_override();
    test_no_override();
`ifdef VRAM_ARB_WPOST_EN
    test_posted_write();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (8-bit data, 1-cycle read latency) between two requesters.
- Requester 1 is the video scanout fetch path. It has top priority because its deadline is fixed by the 25 MHz pixel clock.
- Requester 2 is the AVR CPU data bus, using a request/acknowledge handshake.
- Sits between the video timing generator, the CPU bus decoder and the VRAM, all in the CLK (25 MHz) domain.

Parameters:
- AW, 12: VRAM address width.
- CPU_MAXWAIT, 15: cycles a pending CPU request may be stalled before it overrides video. 0 disables the override.

Ports:
- CLK  in  1  system clock (25 MHz).
- RESET_N  in  1  asynchronous, active-low reset.
- VREQ  in  1  video fetch strobe, one cycle per fetch.
- VADDR  in  AW  video fetch address, valid with VREQ.
- VDATA  out  8  fetched video byte.
- VVALID  out  1  one-cycle pulse, VDATA valid.
- VMISS  out  1  sticky flag: a video fetch was dropped.
- CREQ  in  1  CPU request, level, held until CACK.
- CWE  in  1  CPU write (1) / read (0), valid with CREQ.
- CADDR  in  AW  CPU address.
- CDIN  in  8  CPU write data.
- CDOUT  out  8  CPU read data, valid with CACK on reads.
- CACK  out  1  one-cycle completion pulse.
- RADDR  out  AW  VRAM address (registered).
- RWE  out  1  VRAM write enable (registered).
- RWDATA  out  8  VRAM write data (registered).
- RRDATA  in  8  VRAM read data, valid one cycle after RADDR is sampled by the RAM.

Behaviour:
- Reset (async assert, sync release): all outputs 0, slot pipeline cleared, wait counter 0, CPU-busy flag cleared. An in-flight read is discarded and no VVALID/CACK follows.
- One VRAM slot per cycle. At each edge the arbiter picks a slot owner: NONE, VID or CPU.
- Priority 1 is CPU override: CREQ is pending, CPU is not busy, and the wait counter equals CPU_MAXWAIT (CPU_MAXWAIT != 0). If VREQ is also high that cycle, the video fetch is dropped and VMISS is set.
- Priority 2 is VID: VREQ is high.
- Priority 3 is CPU: CREQ is high and CPU is not busy.
- Priority 4 is NONE: RWE=0, RADDR holds its last value.
- Slot tag shifts through a 2-stage tag pipeline (issue, data).
- Video read: VREQ sampled at edge k -> RADDR=VADDR after k -> RRDATA captured at k+2 -> VDATA/VVALID valid for one cycle after k+2. Fixed latency 2; back-to-back VREQ gives back-to-back VVALID.
- CPU write granted at k: RADDR/RWDATA/RWE=1 after k, CACK pulses in the same cycle as RWE. RWE is deasserted next cycle unless re-granted.
- CPU read granted at k: CPU-busy set; CDOUT/CACK valid after k+2; busy cleared with CACK.
- Only one outstanding CPU operation is allowed. CREQ seen while busy, or in the CACK cycle, is not re-granted.
- Wait counter: increments each cycle CREQ is high and CPU is not granted. It saturates at CPU_MAXWAIT and clears on CPU grant or when CREQ drops.
- CREQ withdrawn before grant: cancelled cleanly, no CACK.
- VREQ and CREQ in the same cycle with counter < CPU_MAXWAIT: video wins, CPU waits.
- Video and CPU slots may alternate every cycle. The tag pipeline routes RRDATA to the correct requester.
- VMISS is cleared only by reset.

Optional Feature:
- Macro VRAM_ARB_WPOST_EN.
- Defined: CPU writes are posted into a 1-entry buffer. CACK pulses the cycle after CREQ is sampled, even if video holds the RAM. The buffer drains in the next slot with CPU-level priority, and the wait/override rules apply to the buffer.
- While the buffer is full, new CPU requests (read or write) are not accepted until the drain slot issues. No read forwarding.
- Undefined: writes acknowledge only when issued to the RAM, as in the base behaviour.

Decomposition:
- Shared include/package vram_pkg:
  - slot tag constants SLOT_NONE=2'd0, SLOT_VID=2'd1, SLOT_CPU=2'd2;
  - default AW;
  - read-latency constant VRAM_RLAT=2.
- Optional sub-module vram_wbuf: posted-write register with full flag and drain handshake. It is instantiated only under VRAM_ARB_WPOST_EN.

Test Plan:
- Reset mid-read: CPU read granted, RESET_N low the next cycle -> no CACK; all outputs 0; VMISS=0.
- VREQ every cycle for 8 cycles, addresses 0x000..0x007, RAM preloaded with data = address -> VVALID 8 consecutive cycles, VDATA 0x00..0x07, first VVALID 2 cycles after first VREQ.
- Simultaneous VREQ (0x010) and CREQ write (0x020, 0x5A) -> video slot first; CPU write in the next free slot; CACK pulse with RWE=1, RADDR=0x020; read-back returns 0x5A.
- Continuous VREQ, CREQ read held, CPU_MAXWAIT=15 -> CPU granted on the 16th cycle; that cycle's VREQ is dropped; VMISS=1 and stays 1.
- CPU_MAXWAIT=0, continuous VREQ, CREQ held -> CPU never granted, VMISS stays 0; CACK 2 cycles after VREQ drops.
- With VRAM_ARB_WPOST_EN, CPU write issued during continuous VREQ -> CACK the next cycle; RAM written in the first non-video (or override) slot; a second CREQ is held off until the buffer drains.
